// File: rtl/demux3_8bit_buf_pkg.sv
// Shared channel codes and select decode for the 3-way byte selector/distributor pair.
// The selector side imports the same decode so a select code names one channel on both sides.
package demux3_8bit_buf_pkg;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;

    // sel[1] has priority, so 2'b11 selects ch2.
    function automatic logic [1:0] sel_decode(input logic [1:0] sel);
        if (sel[1]) begin
            return CH2;
        end else if (sel[0]) begin
            return CH1;
        end else begin
            return CH0;
        end
    endfunction

endpackage

// File: rtl/demux3_8bit_buf_if.sv
// Bus bundle for the 3-way byte distributor: one input stream, three output slots
// with valid/ready handshakes, and the delivered-byte counters.
interface demux3_8bit_buf_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             clr;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y0, y1, y2;
    logic             v0, v1, v2;
    logic             r0, r1, r2;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2;

    modport master (
        output clr, in_data, in_sel, in_valid, r0, r1, r2,
        input  in_ready, y0, y1, y2, v0, v1, v2, cnt0, cnt1, cnt2
    );

    modport slave (
        input  clr, in_data, in_sel, in_valid, r0, r1, r2,
        output in_ready, y0, y1, y2, v0, v1, v2, cnt0, cnt1, cnt2
    );
endinterface

// File: rtl/demux3_8bit_buf_slot.sv
// One-deep holding slot: data register, valid flag, ready term and a wrapping
// delivered-byte counter with synchronous clear.
module demux3_8bit_buf_slot #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             accept,
    input  logic [WIDTH-1:0] din,
    input  logic             take,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic             ready,
    output logic [CNT_W-1:0] cnt
);
    logic             v_q, v_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deliver;

    assign deliver = v_q && take;

    always_comb begin
        v_d   = v_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        // Accept on the same edge as a delivery keeps the slot full with the new byte.
        if (accept) begin
            v_d = 1'b1;
            y_d = din;
        end else if (deliver) begin
            v_d = 1'b0;
        end
        if (clr) begin
            cnt_d = '0;
        end else if (deliver) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= 1'b0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign ready = !v_q || take;
    assign y     = y_q;
    assign valid = v_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux3_8bit_buf.sv
// Routes one byte stream to one of three buffered consumers; holds only the
// channel decode and ready muxing, the slots carry all state.
module demux3_8bit_buf
    import demux3_8bit_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    demux3_8bit_buf_if.slave  bus
);
    logic [1:0] tgt;
    logic [2:0] ready;
    logic [2:0] accept;
    logic       in_ready;

    assign tgt = sel_decode(bus.in_sel);

    // Ready depends only on the selected slot, never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (tgt)
            CH0:     in_ready = ready[0];
            CH1:     in_ready = ready[1];
            CH2:     in_ready = ready[2];
            default: in_ready = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready;

    assign accept[0] = bus.in_valid && in_ready && (tgt == CH0);
    assign accept[1] = bus.in_valid && in_ready && (tgt == CH1);
    assign accept[2] = bus.in_valid && in_ready && (tgt == CH2);

    demux3_8bit_buf_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.clr),
        .accept (accept[0]),
        .din    (bus.in_data),
        .take   (bus.r0),
        .y      (bus.y0),
        .valid  (bus.v0),
        .ready  (ready[0]),
        .cnt    (bus.cnt0)
    );

    demux3_8bit_buf_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.clr),
        .accept (accept[1]),
        .din    (bus.in_data),
        .take   (bus.r1),
        .y      (bus.y1),
        .valid  (bus.v1),
        .ready  (ready[1]),
        .cnt    (bus.cnt1)
    );

    demux3_8bit_buf_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.clr),
        .accept (accept[2]),
        .din    (bus.in_data),
        .take   (bus.r2),
        .y      (bus.y2),
        .valid  (bus.v2),
        .ready  (ready[2]),
        .cnt    (bus.cnt2)
    );

endmodule

// File: doc/demux3_8bit_buf.md
Name: demux3_8bit_buf

Overview:
- Counterpart of the 3:1 byte selector: routes one incoming byte stream to one of three destinations.
- Each destination has a one-deep registered holding slot with a valid/ready handshake and a per-channel delivered-byte counter.
- Sits between the heap datapath's single result bus and the three consumers that the selector reads back from.
- Channel decode uses the same priority as the selector, so a select code written on one side names the same channel on the other.

Parameters:
WIDTH, 8, data width of input bus and each output slot
CNT_W, 8, width of each per-channel delivered-byte counter

Ports:
Clk  input  1  rising-edge clock, single clock domain
Resetn  input  1  asynchronous active-low reset
Clr  input  1  synchronous clear of all three counters; does not touch slots
In_data  input  WIDTH  byte to route
In_sel  input  2  destination select; S[1]=1 -> ch2, else S[0]=1 -> ch1, else ch0
In_valid  input  1  In_data/In_sel valid this cycle
In_ready  output  1  selected channel can accept this cycle
Y0, Y1, Y2  output  WIDTH each  holding-slot data, channels 0/1/2
V0, V1, V2  output  1 each  slot k holds valid data
R0, R1, R2  input  1 each  consumer k takes Yk this cycle
Cnt0, Cnt1, Cnt2  output  CNT_W each  bytes delivered on channel k

Behaviour:
- Reset (Resetn=0, asynchronous, any time): V0..V2=0, Y0..Y2=0, Cnt0..Cnt2=0. A byte in flight is discarded. The first accept can occur on the first rising edge after Resetn returns high.
- Decode (combinational):
  - tgt = 2 if In_sel[1]; else 1 if In_sel[0]; else 0.
  - In_sel=2'b11 selects ch2.
- Ready rule:
  - In_ready = !V[tgt] || R[tgt] (pass-through when the slot drains in the same cycle).
  - In_ready depends on In_sel and R[tgt] only, never on In_valid.
- Accept: In_valid && In_ready at a rising edge.
  - Y[tgt] <= In_data and V[tgt] <= 1.
  - Latency is 1 cycle from accept to V[tgt] high.
  - Non-target slots are unaffected.
- Output handshake: slot k delivers when Vk && Rk at a rising edge.
  - Vk clears unless the same edge also accepts into k; then Vk stays 1 and Yk takes the new byte.
  - Yk is stable while Vk=1 && Rk=0.
  - Yk keeps its last value after Vk drops; it is not zeroed.
- Rk while Vk=0: ignored; no count change.
- Counters:
  - Cntk increments by 1 on each channel-k delivery.
  - Wraps from 2^CNT_W-1 to 0; no saturation or flag.
- Clr:
  - Clr=1 at an edge sets all counters to 0.
  - Clr wins over a simultaneous delivery; that delivery is not counted.
  - Slots and handshakes proceed normally during Clr.
- Simultaneous events: one input accept and up to three output deliveries can occur on the same edge, all independent.
- Blocked input: In_valid=1 with In_ready=0 holds off. The upstream must keep In_data/In_sel stable until accepted.
- No internal state machine beyond the three V flags. Each slot is EMPTY (V=0) or FULL (V=1):
  - EMPTY->FULL on accept.
  - FULL->EMPTY on delivery without accept.
  - FULL->FULL on delivery+accept, or on hold.

Decomposition:
- Shared package constants: CH0=2'd0, CH1=2'd1, CH2=2'd2, and the select-decode function mapping In_sel to a channel index. The selector side uses the same decode.
- Natural sub-module: demux_slot, containing one holding register, its V flag, the ready term and the delivery counter with Clr. Instantiated three times; the top holds decode and ready muxing only.

Test Plan:
1. Reset, then In_sel=00, In_data=8'hA5, In_valid=1 for 1 cycle, R0=1 -> next cycle V0=1, Y0=A5; the cycle after, V0=0 and Cnt0=1; Cnt1 and Cnt2 stay 0.
2. In_sel=11, In_data=8'h3C -> lands in ch2 only (V2=1, Y2=3C); V0 and V1 stay 0, confirming S[1] priority.
3. Fill ch1 with 8'h11 holding R1=0, then present 8'h22 to ch1 -> In_ready=0 and Y1 stays 11. Raise R1 -> same edge delivers 11 and accepts 22: V1 stays 1, Y1=22, Cnt1=1.
4. Deliver 256 bytes on ch0 with R0=1 every cycle -> Cnt0 reaches 8'hFF after 255 deliveries and wraps to 8'h00 on the 256th.
5. Clr=1 on the same edge as a ch2 delivery with Cnt2=5 -> Cnt2=0, not 1; V2 clears normally.
6. Assert Resetn=0 mid-cycle while V0=V1=1 and R0=R1=0 -> all V and Cnt go to 0 immediately, without waiting for Clk. After release, the first accept behaves as in test 1.
